// File: rtl/round_score_timer_if.sv
// Handshake bundle between the round controller and the player/high-score side.
interface round_score_timer_if;
  logic       start;
  logic       correct;
  logic       timerEnable;
  logic       timeout;
  logic [3:0] score10s;
  logic [3:0] score1s;
  logic [3:0] time10s;
  logic [3:0] time1s;

  modport master (
    output start, correct,
    input  timerEnable, timeout, score10s, score1s, time10s, time1s
  );

  modport slave (
    input  start, correct,
    output timerEnable, timeout, score10s, score1s, time10s, time1s
  );
endinterface

// File: rtl/round_score_timer.sv
// Fixed-length game round: BCD seconds countdown plus saturating BCD score,
// with a one-cycle timeout pulse when the round ends.
module round_score_timer #(
  parameter int unsigned TICKS_PER_SEC = 50000000,
  parameter int unsigned GAME_SECONDS  = 60
) (
  input logic                clk,
  input logic                rst,
  round_score_timer_if.slave bus
);

  localparam int unsigned PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [3:0]    INIT10   = 4'(GAME_SECONDS / 10);
  localparam logic [3:0]    INIT1    = 4'(GAME_SECONDS % 10);
  localparam logic [PW-1:0] LAST_PRE = PW'(TICKS_PER_SEC - 1);

  logic [1:0]    state;
  logic [PW-1:0] prescaler;
  logic          timerEnable;
  logic          timeout;
  logic [3:0]    score10s;
  logic [3:0]    score1s;
  logic [3:0]    time10s;
  logic [3:0]    time1s;

  logic lastTick;
  logic scoreFull;

  assign lastTick  = (prescaler == LAST_PRE);
  assign scoreFull = (score10s == 4'd9) && (score1s == 4'd9);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      prescaler   <= '0;
      timerEnable <= 1'b0;
      timeout     <= 1'b0;
      score10s    <= '0;
      score1s     <= '0;
      time10s     <= '0;
      time1s      <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          timeout <= 1'b0;
          if (bus.start) begin
            state       <= RUN;
            prescaler   <= '0;
            timerEnable <= 1'b1;
            score10s    <= '0;
            score1s     <= '0;
            time10s     <= INIT10;
            time1s      <= INIT1;
          end
        end
        RUN: begin
          if (bus.correct && !scoreFull) begin
            if (score1s == 4'd9) begin
              score1s  <= '0;
              score10s <= score10s + 4'd1;
            end else begin
              score1s <= score1s + 4'd1;
            end
          end
          if (lastTick) begin
            prescaler <= '0;
            if (time1s == 4'd0) begin
              time1s  <= 4'd9;
              time10s <= time10s - 4'd1;
            end else begin
              time1s <= time1s - 4'd1;
            end
            // 01 -> 00 is the final decrement; the score update above still lands.
            if ((time10s == 4'd0) && (time1s == 4'd1)) begin
              state       <= DONE;
              timerEnable <= 1'b0;
              timeout     <= 1'b1;
            end
          end else begin
            prescaler <= prescaler + PW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.timerEnable = timerEnable;
  assign bus.timeout     = timeout;
  assign bus.score10s    = score10s;
  assign bus.score1s     = score1s;
  assign bus.time10s     = time10s;
  assign bus.time1s      = time1s;

endmodule

// File: tb/tb_round_score_timer.sv
// Bench for round_score_timer: two instances (3 s and 60 s rounds) checked every
// cycle against an arithmetic round model, plus literal spot checks.
module tb_round_score_timer;

  localparam int T  = 4;
  localparam int GA = 3;
  localparam int GB = 60;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  round_score_timer_if ifA ();
  round_score_timer_if ifB ();

  round_score_timer #(.TICKS_PER_SEC(T), .GAME_SECONDS(GA)) dutA (
    .clk(clk), .rst(rst), .bus(ifA.slave)
  );
  round_score_timer #(.TICKS_PER_SEC(T), .GAME_SECONDS(GB)) dutB (
    .clk(clk), .rst(rst), .bus(ifB.slave)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a round is "elapsed cycles since start"; time left is whole seconds.
  bit mValid = 1'b0;
  bit mRun  [2];
  int mEl   [2];
  int mScore[2];
  int mTime [2];
  bit mTo   [2];

  task automatic step(input int k, input int g, input bit r, input bit s, input bit c);
    if (r) begin
      mRun[k] = 0; mEl[k] = 0; mScore[k] = 0; mTime[k] = 0; mTo[k] = 0;
    end else if (!mRun[k]) begin
      mTo[k] = 0;
      if (s) begin
        mRun[k] = 1; mEl[k] = 0; mScore[k] = 0; mTime[k] = g;
      end
    end else begin
      mTo[k] = 0;
      mEl[k]++;
      if (c && mScore[k] < 99) mScore[k]++;
      mTime[k] = g - mEl[k] / T;
      if (mEl[k] == g * T) begin
        mRun[k] = 0;
        mTo[k]  = 1;
      end
    end
  endtask

  always @(posedge clk) begin
    step(0, GA, rst, ifA.start, ifA.correct);
    step(1, GB, rst, ifB.start, ifB.correct);
    mValid = 1'b1;
  end

  always @(negedge clk) begin
    if (mValid) begin
      chk("A_en",  32'(ifA.timerEnable), 32'(mRun[0]));
      chk("A_to",  32'(ifA.timeout),     32'(mTo[0]));
      chk("A_s10", 32'(ifA.score10s),    32'(mScore[0] / 10));
      chk("A_s1",  32'(ifA.score1s),     32'(mScore[0] % 10));
      chk("A_t10", 32'(ifA.time10s),     32'(mTime[0] / 10));
      chk("A_t1",  32'(ifA.time1s),      32'(mTime[0] % 10));
      chk("B_en",  32'(ifB.timerEnable), 32'(mRun[1]));
      chk("B_to",  32'(ifB.timeout),     32'(mTo[1]));
      chk("B_s10", 32'(ifB.score10s),    32'(mScore[1] / 10));
      chk("B_s1",  32'(ifB.score1s),     32'(mScore[1] % 10));
      chk("B_t10", 32'(ifB.time10s),     32'(mTime[1] / 10));
      chk("B_t1",  32'(ifB.time1s),      32'(mTime[1] % 10));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic litA(input string name, input int en, input int to, input int sc, input int tm);
    chk({name, "_en"},  32'(ifA.timerEnable), 32'(en));
    chk({name, "_to"},  32'(ifA.timeout),     32'(to));
    chk({name, "_s10"}, 32'(ifA.score10s),    32'(sc / 10));
    chk({name, "_s1"},  32'(ifA.score1s),     32'(sc % 10));
    chk({name, "_t10"}, 32'(ifA.time10s),     32'(tm / 10));
    chk({name, "_t1"},  32'(ifA.time1s),      32'(tm % 10));
  endtask

  initial begin
    ifA.start = 0; ifA.correct = 0;
    ifB.start = 0; ifB.correct = 0;
    rst = 1;
    tick(2);
    rst = 0;
    litA("reset", 0, 0, 0, 0);

    // Round 1: correct on E1..E12, final one coincides with the last decrement.
    ifA.start = 1;
    tick(1);
    ifA.start = 0;
    for (int k = 1; k <= 12; k++) begin
      if (k == 5) litA("after_E4", 1, 0, 4, 2);
      ifA.correct = 1;
      tick(1);
    end
    ifA.correct = 0;
    litA("timeout12", 0, 1, 12, 0);
    tick(3);
    litA("hold12", 0, 0, 12, 0);

    // Round 2: start from DONE, score 05, start at E6 ignored, correct at E12.
    ifA.start = 1;
    tick(1);
    ifA.start = 0;
    litA("restart", 1, 0, 0, 3);
    for (int k = 1; k <= 12; k++) begin
      ifA.correct = (k <= 5) || (k == 12);
      ifA.start   = (k == 6);
      tick(1);
    end
    ifA.correct = 0;
    ifA.start   = 0;
    litA("timeout06", 0, 1, 6, 0);

    // Round 3: start held through the round and into DONE.
    tick(2);
    ifA.start = 1;
    tick(13);
    litA("held_to", 0, 1, 0, 0);
    tick(1);
    litA("held_rerun", 1, 0, 0, 3);
    ifA.start = 0;

    // Reset mid-round, then correct in IDLE is ignored.
    tick(5);
    rst = 1;
    tick(1);
    rst = 0;
    litA("midrst", 0, 0, 0, 0);
    ifA.correct = 1;
    tick(1);
    ifA.correct = 0;
    litA("idle_corr", 0, 0, 0, 0);

    // 60 s round with 105 corrects: saturation at 99.
    ifB.start = 1;
    tick(1);
    ifB.start = 0;
    for (int k = 1; k <= 105; k++) begin
      ifB.correct = 1;
      tick(1);
    end
    ifB.correct = 0;
    chk("B_sat10", 32'(ifB.score10s), 32'd9);
    chk("B_sat1",  32'(ifB.score1s),  32'd9);
    for (int i = 0; i < 400 && ifB.timeout !== 1'b1; i++) tick(1);
    chk("B_timeout", 32'(ifB.timeout),  32'd1);
    chk("B_final10", 32'(ifB.score10s), 32'd9);
    chk("B_final1",  32'(ifB.score1s),  32'd9);
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
